// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
// State encoding is visible on the debug port, so its values are fixed.
package fetch_ctrl_pkg;

  localparam int unsigned DEF_PC_W = 12;
  localparam logic [DEF_PC_W-1:0] DEF_RESET_VEC = 12'd0;
  localparam int unsigned PERF_W = 16;
  localparam int unsigned HOLD_W = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating event counter with enable; sticks at all-ones.
module fetch_perf_cnt
  import fetch_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + PERF_W'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, boot hold-off, redirects, halt/resume.
// Defining FETCH_CTRL_PERF_EN adds fetched/stalled-cycle counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W      = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEF_RESET_VEC),
  parameter int unsigned     BOOT_HOLD = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              jump,
  input  logic [PC_W-1:0]   jump_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic [PC_W-1:0]   iaddr_PC,
  output logic              valid_f,
  output logic              flush_fd,
`ifdef FETCH_CTRL_PERF_EN
  output logic [PERF_W-1:0] perf_fetched,
  output logic [PERF_W-1:0] perf_stalls,
`endif
  output logic [1:0]        state
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              valid_q, valid_d;
  logic              flush_q, flush_d;

  // State and registered outputs; reset wins over any pending redirect.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      hold_q  <= HOLD_W'(BOOT_HOLD);
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
    end
  end

  // Next state, next PC and next output values.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    valid_d = 1'b0;
    flush_d = 1'b0;
    case (state_q)
      BOOT: begin
        if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
        if (hold_q <= HOLD_W'(1)) begin
          state_d = RUN;
          valid_d = 1'b1;
        end
      end
      RUN: begin
        valid_d = 1'b1;
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = REDIR;
          valid_d = 1'b0;
          flush_d = 1'b1;
        end else if (jump) begin
          pc_d    = jump_target;
          state_d = REDIR;
          valid_d = 1'b0;
          flush_d = 1'b1;
        end else if (halt_req) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else if (!stall) begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      REDIR: begin
        state_d = RUN;
        valid_d = 1'b1;
      end
      HALT: begin
        if (resume) begin
          state_d = RUN;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign iaddr_PC = pc_q;
  assign valid_f  = valid_q;
  assign flush_fd = flush_q;
  assign state    = state_q;

`ifdef FETCH_CTRL_PERF_EN
  logic run_seq_c;
  logic adv_c;
  logic stalled_c;

  // Only the lowest-priority RUN outcomes count as fetch advance or stall.
  assign run_seq_c = (state_q == RUN) && !branch_taken && !jump && !halt_req;
  assign adv_c     = run_seq_c && !stall;
  assign stalled_c = run_seq_c && stall;

  fetch_perf_cnt u_perf_fetched (
    .clock (clock),
    .reset (reset),
    .en    (adv_c),
    .count (perf_fetched)
  );

  fetch_perf_cnt u_perf_stalls (
    .clock (clock),
    .reset (reset),
    .en    (stalled_c),
    .count (perf_stalls)
  );
`endif

endmodule
